// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the unified-memory port arbiter
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  function automatic arb_state_t busy_of(owner_t own);
    return (own == OWN_D) ? BUSY_D : BUSY_I;
  endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// rtl/arb_starve_cnt.sv - saturating count of data grants taken while fetch waits
module arb_starve_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] cnt;

  assign sat = (cnt == CNT_W'(STARVE_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data access
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_abort,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall_F,
  output logic              stall_M,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t state;
  logic       abort_seen;
  logic       is_idle;
  logic       grant_d;
  logic       grant_i;
  logic       cnt_inc;
  logic       cnt_clr;
  logic       cnt_sat;

  // Data wins unless fetch has already been passed over STARVE_MAX times in a row.
  assign is_idle = (state == IDLE);
  assign grant_d = is_idle & d_req & ~(i_req & cnt_sat);
  assign grant_i = is_idle & ~grant_d & i_req & ~i_abort;
  assign cnt_inc = grant_d & i_req & ~i_abort;
  assign cnt_clr = grant_i | (is_idle & ~i_req);

  arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk  (clk),
    .reset(reset),
    .inc  (cnt_inc),
    .clr  (cnt_clr),
    .sat  (cnt_sat)
  );

  assign mem_req = (state == BUSY_I) | (state == BUSY_D);
  assign i_done  = (state == RESP_I) & ~abort_seen & ~i_abort;
  assign d_done  = (state == RESP_D);
  assign stall_F = i_req & ~i_done & ~i_abort;
  assign stall_M = d_req & ~d_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      abort_seen <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          abort_seen <= 1'b0;
          if (grant_d) begin
            state     <= busy_of(OWN_D);
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (grant_i) begin
            state    <= busy_of(OWN_I);
            mem_we   <= 1'b0;
            mem_addr <= i_addr;
          end
        end
        BUSY_I: begin
          // An aborted fetch still runs to completion; only its result is discarded.
          if (i_abort) begin
            abort_seen <= 1'b1;
          end
          if (mem_ready) begin
            state <= RESP_I;
            if (!abort_seen && !i_abort) begin
              i_rdata <= mem_rdata;
            end
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            state <= RESP_D;
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
          end
        end
        RESP_D: begin
          state  <= IDLE;
          mem_we <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed bench with transaction-level reference model
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_req = 1'b0, i_abort = 1'b0, i_done;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0, d_we = 1'b0, d_done;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0, d_rdata;
  logic          stall_F, stall_M;
  logic          mem_req, mem_we, mem_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata = '0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_abort(i_abort), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata),
    .stall_F(stall_F), .stall_M(stall_M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  initial forever #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one access record, a starve count and the two read-data holders.
  bit            m_busy = 0, m_fetch = 0, m_resp = 0, m_abt = 0;
  logic          m_we = 0;
  logic [31:0]   m_addr = 0, m_wdata = 0, m_ird = 0, m_drd = 0;
  int            m_starve = 0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_busy = 0; m_fetch = 0; m_resp = 0; m_abt = 0; m_we = 0;
      m_addr = 0; m_wdata = 0; m_ird = 0; m_drd = 0; m_starve = 0;
    end else if (!m_busy) begin
      if (d_req && !(i_req && m_starve == SMAX)) begin
        m_busy = 1; m_fetch = 0; m_resp = 0; m_abt = 0;
        m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
        if (i_req && !i_abort && m_starve < SMAX) m_starve++;
      end else if (i_req && !i_abort) begin
        m_busy = 1; m_fetch = 1; m_resp = 0; m_abt = 0;
        m_we = 0; m_addr = i_addr; m_starve = 0;
      end
      if (!i_req) m_starve = 0;
    end else if (!m_resp) begin
      if (m_fetch && i_abort) m_abt = 1;
      if (mem_ready) begin
        m_resp = 1;
        if (m_fetch && !m_abt) m_ird = mem_rdata;
        if (!m_fetch && !m_we) m_drd = mem_rdata;
      end
    end else begin
      m_busy = 0;
    end
  end

  // Compare process and event monitor, sampled on the falling edge.
  bit          i_done_s = 0, d_done_s = 0;
  int          i_done_cnt = 0, d_done_cnt = 0;
  logic [31:0] mlog_addr[$];
  logic [31:0] mlog_wdata[$];
  logic        mlog_we[$];

  initial forever begin
    logic e_req, e_id, e_dd;
    @(negedge clk);
    if (!reset) begin
      e_req = m_busy && !m_resp;
      e_dd  = m_busy && m_resp && !m_fetch;
      e_id  = m_busy && m_resp && m_fetch && !m_abt && !i_abort;
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("i_done", 32'(i_done), 32'(e_id));
      chk("d_done", 32'(d_done), 32'(e_dd));
      chk("stall_F", 32'(stall_F), 32'(i_req && !e_id && !i_abort));
      chk("stall_M", 32'(stall_M), 32'(d_req && !e_dd));
      chk("i_rdata", i_rdata, m_ird);
      chk("d_rdata", d_rdata, m_drd);
      if (e_req) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_we", 32'(mem_we), 32'(m_we));
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
    end
    i_done_s = i_done;
    d_done_s = d_done;
    if (i_done) i_done_cnt++;
    if (d_done) d_done_cnt++;
    if (mem_req && mem_ready) begin
      mlog_addr.push_back(mem_addr);
      mlog_we.push_back(mem_we);
      mlog_wdata.push_back(mem_wdata);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus: requesters, memory responder and the test sequence all live in this process.
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} dreq_t;
  dreq_t       dq[$];
  logic [31:0] iq[$];
  bit          rand_mode = 0, idle_noise = 0, fixed_en = 1, abort_pend = 0, ab_last = 0;
  logic [31:0] fixed_rdata = 0;
  int          rd_cfg = 0, rd_cnt = 0, rd_delay = 0;

  task automatic push_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    dreq_t r;
    r.we = we; r.addr = addr; r.wdata = wdata;
    dq.push_back(r);
  endtask

  task automatic step();
    dreq_t r;
    @(posedge clk);
    #1;
    if (mem_req) begin
      if (rd_cnt == 0) rd_delay = (rd_cfg >= 0) ? rd_cfg : int'($urandom_range(0, 2));
      if (rd_cnt == rd_delay) begin
        mem_ready = 1'b1;
        mem_rdata = fixed_en ? (fixed_rdata ^ mem_addr) : $urandom;
        rd_cnt = 0;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        rd_cnt++;
      end
    end else begin
      rd_cnt = 0;
      mem_ready = idle_noise ? 1'($urandom % 2) : 1'b0;
      mem_rdata = $urandom;
    end
    i_abort = 1'b0;
    if (reset) begin
      d_req = 0; i_req = 0; ab_last = 0; abort_pend = 0;
      dq.delete(); iq.delete();
    end else begin
      if (d_req && d_done_s) d_req = 0;
      if (!d_req) begin
        if (dq.size() > 0) begin
          r = dq.pop_front();
          d_req = 1; d_we = r.we; d_addr = r.addr; d_wdata = r.wdata;
        end else if (rand_mode && $urandom % 3 == 0) begin
          d_req = 1; d_we = 1'($urandom % 2); d_addr = $urandom & ~32'h3; d_wdata = $urandom;
        end
      end
      if (i_req && (i_done_s || ab_last)) i_req = 0;
      if (!i_req) begin
        if (iq.size() > 0) begin
          i_req = 1; i_addr = iq.pop_front();
        end else if (rand_mode && $urandom % 3 == 0) begin
          i_req = 1; i_addr = $urandom & ~32'h3;
        end
      end
      if (i_req && (abort_pend || (rand_mode && $urandom % 10 == 0))) begin
        i_abort = 1'b1;
        abort_pend = 0;
      end
      ab_last = i_abort;
    end
  endtask

  initial begin
    int ib, db, mb, first_done, pos;
    bit ok, found;

    repeat (3) step();
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_i_done", 32'(i_done), 32'd0);
    chk("rst_d_done", 32'(d_done), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    reset = 1'b0;
    repeat (2) step();

    // Lone fetch, memory answers two cycles after mem_req rises.
    fixed_rdata = 32'h00500193; rd_cfg = 2;
    ib = i_done_cnt; mb = mlog_addr.size(); first_done = -1; ok = 1;
    iq.push_back(32'h100);
    for (int n = 0; n < 12; n++) begin
      step();
      @(negedge clk);
      if (i_done && first_done < 0) first_done = n;
      if (first_done < 0 && i_req && !stall_F) ok = 0;
    end
    chk("t1_done_cycle", 32'(first_done), 32'd4);
    chk("t1_done_count", 32'(i_done_cnt - ib), 32'd1);
    chk("t1_i_rdata", i_rdata, 32'h00500093);
    chk("t1_stall_F_held", 32'(ok), 32'd1);
    chk("t1_mem_addr", mlog_addr[mb], 32'h100);

    // Load then store back-to-back.
    fixed_rdata = 32'h11221344; rd_cfg = 0;
    db = d_done_cnt; mb = mlog_addr.size();
    push_d(1'b0, 32'h2000, 32'h0);
    push_d(1'b1, 32'h2004, 32'hDEADBEEF);
    repeat (12) begin step(); @(negedge clk); end
    chk("t2_done_count", 32'(d_done_cnt - db), 32'd2);
    chk("t2_we0", 32'(mlog_we[mb]), 32'd0);
    chk("t2_we1", 32'(mlog_we[mb+1]), 32'd1);
    chk("t2_store_addr", mlog_addr[mb+1], 32'h2004);
    chk("t2_store_wdata", mlog_wdata[mb+1], 32'hDEADBEEF);
    chk("t2_d_rdata_kept", d_rdata, 32'h11223344);

    // Simultaneous requests: data first; then starvation limit.
    fixed_rdata = 32'h0BAD0000;
    mb = mlog_addr.size();
    push_d(1'b0, 32'h2008, 32'h0);
    iq.push_back(32'h1000);
    repeat (12) begin step(); @(negedge clk); end
    chk("t3_first_data", mlog_addr[mb], 32'h2008);
    chk("t3_then_fetch", mlog_addr[mb+1], 32'h1000);
    mb = mlog_addr.size();
    for (int k = 0; k < 6; k++) push_d(1'b0, 32'h2100 + 32'(4 * k), 32'h0);
    iq.push_back(32'h1004);
    repeat (40) begin step(); @(negedge clk); end
    pos = -1;
    for (int k = mb; k < mlog_addr.size(); k++) if (mlog_addr[k] == 32'h1004 && pos < 0) pos = k - mb;
    chk("t3_starve_pos", 32'(pos), 32'd4);
    chk("t3_access_count", 32'(mlog_addr.size() - mb), 32'd7);

    // Abort during BUSY_I, new fetch raised right after the abort.
    fixed_rdata = 32'hCAFE0000; rd_cfg = 3;
    ib = i_done_cnt; mb = mlog_addr.size(); found = 0; ok = 1;
    iq.push_back(32'h300);
    for (int n = 0; n < 10 && !found; n++) begin step(); @(negedge clk); if (mem_req) found = 1; end
    chk("t4_grant_seen", 32'(found), 32'd1);
    abort_pend = 1;
    iq.push_back(32'h304);
    repeat (20) begin
      step();
      @(negedge clk);
      if (mlog_addr.size() - mb < 2 && i_rdata != 32'h0BAD1004) ok = 0;
    end
    chk("t4_i_rdata_kept", 32'(ok), 32'd1);
    chk("t4_access_count", 32'(mlog_addr.size() - mb), 32'd2);
    chk("t4_aborted_addr", mlog_addr[mb], 32'h300);
    chk("t4_done_count", 32'(i_done_cnt - ib), 32'd1);
    chk("t4_next_rdata", i_rdata, 32'hCAFE0304);

    // Reset in the middle of a data access.
    rd_cfg = 5; found = 0; db = d_done_cnt;
    push_d(1'b0, 32'h2200, 32'h0);
    for (int n = 0; n < 10 && !found; n++) begin step(); @(negedge clk); if (mem_req) found = 1; end
    chk("t5_busy_seen", 32'(found), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_mem_req", 32'(mem_req), 32'd0);
    chk("t5_d_done", 32'(d_done), 32'd0);
    chk("t5_d_rdata", d_rdata, 32'd0);
    chk("t5_mem_addr", mem_addr, 32'd0);
    repeat (2) step();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin step(); @(negedge clk); end
    chk("t5_no_done", 32'(d_done_cnt - db), 32'd0);

    // Stray mem_ready while idle, then one access each with requests held through RESP.
    idle_noise = 1; rd_cfg = 1;
    ib = i_done_cnt; db = d_done_cnt; mb = mlog_addr.size();
    repeat (10) begin step(); @(negedge clk); end
    chk("t6_idle_i_done", 32'(i_done_cnt - ib), 32'd0);
    chk("t6_idle_d_done", 32'(d_done_cnt - db), 32'd0);
    chk("t6_idle_access", 32'(mlog_addr.size() - mb), 32'd0);
    push_d(1'b0, 32'h2300, 32'h0);
    iq.push_back(32'h1100);
    repeat (16) begin step(); @(negedge clk); end
    chk("t6_d_done", 32'(d_done_cnt - db), 32'd1);
    chk("t6_i_done", 32'(i_done_cnt - ib), 32'd1);
    chk("t6_access", 32'(mlog_addr.size() - mb), 32'd2);

    // Randomized traffic checked cycle by cycle against the model.
    rand_mode = 1; fixed_en = 0; rd_cfg = -1;
    ib = i_done_cnt; db = d_done_cnt;
    repeat (3000) step();
    rand_mode = 0;
    repeat (30) step();
    @(negedge clk);
    chk("rand_activity", 32'((i_done_cnt > ib) && (d_done_cnt > db)), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
